// File: rtl/tohost_monitor.sv
// tohost_monitor: device end of the riscv-tests tohost protocol, decoding result stores into sticky run status.
// Optional watchdog enabled by defining TOHOST_MONITOR_TIMEOUT_EN.
module tohost_monitor #(
    parameter logic [31:0] TOHOST_ADDR   = 32'h0000_1000,
    parameter logic [31:0] FROMHOST_ADDR = 32'h0000_1040,
    parameter int unsigned TIMEOUT       = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,
    input  logic        rd_valid,
    output logic        rd_ready,
    input  logic [31:0] rd_addr,
    output logic        rd_resp_valid,
    output logic [31:0] rd_data,
    output logic        done,
    output logic        pass,
    output logic [30:0] fail_code,
    output logic        done_pulse,
    output logic        halt,
    output logic [31:0] cycles
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] tohost_q_r;
    logic [31:0] tohost_next_s;
    logic [31:0] cycles_r;
    logic [31:0] cycles_next_s;
    logic [30:0] fail_code_r;
    logic [30:0] fail_code_next_s;
    logic        done_r;
    logic        pass_r;
    logic        done_pulse_r;
    logic        rd_resp_valid_r;
    logic [31:0] rd_data_r;
    logic        th_wr_s;
    logic        wdog_hit_s;
    logic [31:0] rd_data_s;

    // Load data mux; only word address bits take part in decode.
    function automatic logic [31:0] load_value(input logic [31:0] addr, input logic [31:0] tohost_val);
        if (addr[31:2] == TOHOST_ADDR[31:2]) begin
            return tohost_val;
        end else if (addr[31:2] == FROMHOST_ADDR[31:2]) begin
            return 32'h0000_0000;
        end else begin
            return 32'hDEAD_BEEF;
        end
    endfunction

    wire unused_s = &{1'b0, wr_addr[1:0], rd_addr[1:0], TIMEOUT[0]};

    assign wr_ready = 1'b1;
    assign rd_ready = 1'b1;

    assign th_wr_s   = wr_valid && (wr_addr[31:2] == TOHOST_ADDR[31:2]) && (wr_strb == 4'hF);
    assign rd_data_s = load_value(rd_addr, tohost_q_r);

`ifdef TOHOST_MONITOR_TIMEOUT_EN
    assign wdog_hit_s = (cycles_r == TIMEOUT);
`else
    assign wdog_hit_s = 1'b0;
`endif

    // Next-state decode; a decoding store outranks the watchdog in the same cycle.
    always_comb begin
        state_next_s     = state_r;
        tohost_next_s    = tohost_q_r;
        fail_code_next_s = fail_code_r;
        case (state_r)
            ST_RUN: begin
                if (th_wr_s) begin
                    tohost_next_s = wr_data;
                end else begin
                    tohost_next_s = tohost_q_r;
                end
                if (th_wr_s && (wr_data == 32'h0000_0001)) begin
                    state_next_s = ST_PASS;
                end else if (th_wr_s && wr_data[0]) begin
                    state_next_s     = ST_FAIL;
                    fail_code_next_s = wr_data[31:1];
                end else if (wdog_hit_s) begin
                    state_next_s     = ST_TIMEOUT;
                    fail_code_next_s = 31'h7FFF_FFFF;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_PASS, ST_FAIL, ST_TIMEOUT: begin
                state_next_s = state_r;
            end
            default: begin
                state_next_s = ST_RUN;
            end
        endcase
    end

    // Run-time counter: advances only while running, saturating at all-ones.
    always_comb begin
        cycles_next_s = cycles_r;
        if ((state_r == ST_RUN) && (cycles_r != 32'hFFFF_FFFF)) begin
            cycles_next_s = cycles_r + 32'd1;
        end else begin
            cycles_next_s = cycles_r;
        end
    end

    // Run status registers and their registered output views.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_RUN;
            tohost_q_r   <= 32'h0000_0000;
            cycles_r     <= 32'h0000_0000;
            fail_code_r  <= 31'h0000_0000;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            done_pulse_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            tohost_q_r   <= tohost_next_s;
            cycles_r     <= cycles_next_s;
            fail_code_r  <= fail_code_next_s;
            done_r       <= (state_next_s != ST_RUN);
            pass_r       <= (state_next_s == ST_PASS);
            done_pulse_r <= (state_r == ST_RUN) && (state_next_s != ST_RUN);
        end
    end

    // Load response pipeline: one response cycle per accepted load, reading pre-store tohost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_resp_valid_r <= 1'b0;
            rd_data_r       <= 32'h0000_0000;
        end else begin
            rd_resp_valid_r <= rd_valid;
            rd_data_r       <= rd_valid ? rd_data_s : 32'h0000_0000;
        end
    end

    assign done          = done_r;
    assign pass          = pass_r;
    assign halt          = done_r;
    assign fail_code     = fail_code_r;
    assign done_pulse    = done_pulse_r;
    assign cycles        = cycles_r;
    assign rd_resp_valid = rd_resp_valid_r;
    assign rd_data       = rd_data_r;

endmodule

// File: tb/tb_tohost_monitor.sv
// Randomized bench for tohost_monitor against a behavioural run-status model.
// Watchdog expectations follow TOHOST_MONITOR_TIMEOUT_EN.
module tb_tohost_monitor;

    localparam int unsigned TO = 50;
`ifdef TOHOST_MONITOR_TIMEOUT_EN
    localparam bit WDOG_EN = 1'b1;
`else
    localparam bit WDOG_EN = 1'b0;
`endif
    localparam int M_RUN = 0, M_PASS = 1, M_FAIL = 2, M_TO = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_addr = 32'h0;
    logic [31:0] wr_data = 32'h0;
    logic [3:0]  wr_strb = 4'h0;
    logic        rd_valid = 1'b0;
    logic        rd_ready;
    logic [31:0] rd_addr = 32'h0;
    logic        rd_resp_valid;
    logic [31:0] rd_data;
    logic        done;
    logic        pass;
    logic [30:0] fail_code;
    logic        done_pulse;
    logic        halt;
    logic [31:0] cycles;

    int n_tests = 0;
    int n_fail  = 0;

    int          m_state;
    logic [31:0] m_tohost;
    logic [31:0] m_cycles;
    logic [30:0] m_fail;
    logic        m_pulse;
    logic        m_rv;
    logic [31:0] m_rd;

    tohost_monitor #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_resp_valid(rd_resp_valid), .rd_data(rd_data),
        .done(done), .pass(pass), .fail_code(fail_code), .done_pulse(done_pulse),
        .halt(halt), .cycles(cycles)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state  = M_RUN;
        m_tohost = 32'h0;
        m_cycles = 32'h0;
        m_fail   = 31'h0;
        m_pulse  = 1'b0;
        m_rv     = 1'b0;
        m_rd     = 32'h0;
    endtask

    task automatic check_outputs();
        check_eq("wr_ready", {63'h0, wr_ready}, 64'h1);
        check_eq("rd_ready", {63'h0, rd_ready}, 64'h1);
        check_eq("done", {63'h0, done}, {63'h0, m_state != M_RUN});
        check_eq("halt", {63'h0, halt}, {63'h0, m_state != M_RUN});
        check_eq("pass", {63'h0, pass}, {63'h0, m_state == M_PASS});
        check_eq("fail_code", {33'h0, fail_code}, {33'h0, m_fail});
        check_eq("done_pulse", {63'h0, done_pulse}, {63'h0, m_pulse});
        check_eq("cycles", {32'h0, cycles}, {32'h0, m_cycles});
        check_eq("rd_resp_valid", {63'h0, rd_resp_valid}, {63'h0, m_rv});
        if (m_rv) check_eq("rd_data", {32'h0, rd_data}, {32'h0, m_rd});
    endtask

    // One clock: drive at negedge, advance model by spec rules, check at next negedge.
    task automatic step(input logic wv, input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                        input logic rv, input logic [31:0] ra);
        bit is_th;
        wr_valid = wv; wr_addr = wa; wr_data = wd; wr_strb = ws;
        rd_valid = rv; rd_addr = ra;
        m_rv = rv;
        if (ra[31:2] == 30'h400)      m_rd = m_tohost;
        else if (ra[31:2] == 30'h410) m_rd = 32'h0;
        else                          m_rd = 32'hDEAD_BEEF;
        m_pulse = 1'b0;
        if (m_state == M_RUN) begin
            is_th = wv && (wa[31:2] == 30'h400) && (ws == 4'hF);
            if (is_th) m_tohost = wd;
            if (is_th && wd == 32'h1) begin
                m_state = M_PASS; m_pulse = 1'b1;
            end else if (is_th && wd[0]) begin
                m_state = M_FAIL; m_fail = wd[31:1]; m_pulse = 1'b1;
            end else if (WDOG_EN && m_cycles == TO) begin
                m_state = M_TO; m_fail = 31'h7FFF_FFFF; m_pulse = 1'b1;
            end
            if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 32'd1;
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
    endtask

    task automatic store(input logic [31:0] wd, input logic [3:0] ws);
        step(1'b1, 32'h0000_1000, wd, ws, 1'b0, 32'h0);
    endtask

    // Asynchronous reset asserted mid-cycle, then released at a negedge.
    task automatic apply_reset();
        wr_valid = 1'b0; rd_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        rst = 1'b1;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned k = $urandom_range(9, 0);
        if (k < 6)      return 32'h0000_1000 | ($urandom & 32'h3);
        else if (k < 8) return 32'h0000_1040 | ($urandom & 32'h3);
        else            return $urandom;
    endfunction

    function automatic logic [31:0] rand_data();
        case ($urandom_range(3, 0))
            0:       return 32'h1;
            1:       return $urandom & 32'hFFFF_FFFE;
            2:       return $urandom | 32'h1;
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        rst = 1'b1;

        // Pass after 20 idle cycles; cycles freezes one past the store cycle.
        repeat (20) idle();
        store(32'h1, 4'hF);
        check_eq("pass_cycles", {32'h0, cycles}, 64'd21);
        check_eq("pass_flag", {63'h0, pass}, 64'h1);
        idle();
        check_eq("pulse_drop", {63'h0, done_pulse}, 64'h0);
        idle();
        check_eq("pass_frozen", {32'h0, cycles}, 64'd21);

        // Fail code decode, and terminal state ignores later pass store.
        apply_reset();
        store(32'h0000_0007, 4'hF);
        check_eq("fail_code_3", {33'h0, fail_code}, 64'd3);
        store(32'h1, 4'hF);
        check_eq("fail_sticky", {63'h0, pass}, 64'h0);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0000_1000);
        check_eq("frozen_tohost", {32'h0, rd_data}, 64'h7);

        // Partial strobe ignored, even value stored, load returns it once.
        apply_reset();
        store(32'h1, 4'h3);
        store(32'h0, 4'hF);
        check_eq("still_run", {63'h0, done}, 64'h0);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0000_1000);
        check_eq("load_zero", {32'h0, rd_data}, 64'h0);
        idle();
        check_eq("resp_one_cycle", {63'h0, rd_resp_valid}, 64'h0);

        // Load and store at the same edge see the old value.
        store(32'h0000_0ABC, 4'hF);
        step(1'b1, 32'h0000_1000, 32'h0000_0124, 4'hF, 1'b1, 32'h0000_1000);
        check_eq("old_tohost", {32'h0, rd_data}, 64'hABC);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0000_1040);
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0000_2000);

        // Idle run: watchdog fires at the limit or run continues.
        apply_reset();
        repeat (200) idle();
        check_eq("idle_done", {63'h0, done}, {63'h0, WDOG_EN});

        // Store exactly at the watchdog limit: the store wins.
        apply_reset();
        repeat (TO) idle();
        check_eq("at_limit", {32'h0, cycles}, TO);
        store(32'h1, 4'hF);
        check_eq("store_beats_wdog", {63'h0, pass}, 64'h1);

        // Reset during a pending load response after pass.
        step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0000_1000);
        apply_reset();
        idle();
        check_eq("restart_cycles", {32'h0, cycles}, 64'd1);

        // Randomized episodes, each ended by a mid-run reset.
        for (int ep = 0; ep < 12; ep++) begin
            apply_reset();
            for (int c = 0; c < 90; c++) begin
                step(($urandom_range(7, 0) == 0), rand_addr(), rand_data(),
                     ($urandom_range(4, 0) != 0) ? 4'hF : 4'($urandom),
                     ($urandom_range(2, 0) == 0), rand_addr());
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tohost_monitor.md
# tohost_monitor

Memory-mapped test-completion responder on the core's data bus. It is the device end of the riscv-tests `tohost` protocol: the core stores a result word, and the monitor decodes it into sticky pass/fail status, a fail code, a halt request and a cycle count. An optional watchdog ends runs that never report. The simulation top reads the monitor's status outputs; it does not inspect architectural registers.

## Interface
Parameters:
- `TOHOST_ADDR`, 32'h0000_1000: word address of `tohost`.
- `FROMHOST_ADDR`, 32'h0000_1040: word address of `fromhost`.
- `TIMEOUT`, 5000: cycle budget before the watchdog fires. Must be ≥ 2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `wr_valid` in 1: store request from the core.
- `wr_ready` out 1: store accepted.
- `wr_addr` in 32: store byte address.
- `wr_data` in 32: store data.
- `wr_strb` in 4: byte enables.
- `rd_valid` in 1: load request.
- `rd_ready` out 1: load accepted.
- `rd_addr` in 32: load byte address.
- `rd_resp_valid` out 1: load data valid.
- `rd_data` out 32: load data.
- `done` out 1: sticky; the run has ended.
- `pass` out 1: sticky; the run passed.
- `fail_code` out 31: failing test number, or all-ones on timeout.
- `done_pulse` out 1: one-cycle strobe on entry to the ended state.
- `halt` out 1: request to the core to stop fetching. Equals `done`.
- `cycles` out 32: cycles spent in RUN, saturating at 32'hFFFF_FFFF.

## Operation
- State register with four states: RUN, PASS, FAIL, TIMEOUT. Reset state is RUN.
- `wr_ready` and `rd_ready` are constant 1. A request is accepted in any cycle where its valid is high.
- A store is a tohost write when `wr_addr[31:2]` equals `TOHOST_ADDR[31:2]` and `wr_strb` is 4'hF. Other stores are accepted and dropped.
- A tohost write in RUN stores `wr_data` in the `tohost_q` register, then decodes it:
  - Value 32'h1: go to PASS.
  - Bit0 is 1 and value is not 1: go to FAIL; `fail_code` ← `wr_data[31:1]`.
  - Bit0 is 0, including value 0: no state change; `tohost_q` is still updated.
- In PASS, FAIL and TIMEOUT, all stores are dropped and `tohost_q` is frozen. These states are exited only by reset.
- Watchdog: in RUN, when `cycles` equals `TIMEOUT` and no decoding tohost write is accepted in that cycle, go to TIMEOUT; `fail_code` ← 31'h7FFF_FFFF.
- Loads:
  - To `TOHOST_ADDR`: return `tohost_q`.
  - To `FROMHOST_ADDR`: return 0.
  - Any other address: return 32'hDEAD_BEEF.
- `done` is 1 in PASS, FAIL and TIMEOUT. `pass` is 1 only in PASS.

## Timing
- Reset values: state RUN, `tohost_q` 0, `cycles` 0, `fail_code` 0, `done`/`pass`/`done_pulse`/`halt`/`rd_resp_valid` 0, `rd_data` 0.
- All outputs are registered except `wr_ready` and `rd_ready`.
- Store accepted at edge N: state, `done`, `pass`, `fail_code` and `done_pulse` are visible after edge N. `done_pulse` drops after edge N+1.
- Load accepted at edge N: `rd_resp_valid` is 1 with `rd_data` for exactly the cycle after edge N. Back-to-back loads give back-to-back responses.
- A load and a tohost store accepted at the same edge: the load returns the old `tohost_q`.
- `cycles` increments on every edge while in RUN, starting with the first edge after reset deasserts. It holds in terminal states.
- Decoding write at the same edge as the timeout condition: the write wins (PASS or FAIL).
- Reset asserted at any time returns to RUN immediately and clears all status. Any pending load response is lost.

## Configuration
- `TOHOST_MONITOR_TIMEOUT_EN` defined: watchdog active as described in Operation.
- Not defined: the TIMEOUT state is unreachable and `TIMEOUT` is ignored. `cycles` still counts and saturates.

## Test plan
- Store 32'h1 to 0x1000 with strobe F at cycle 20 → `done`=1 and `pass`=1 from cycle 21; `done_pulse` high one cycle; `cycles` frozen at 21.
- Store 32'h0000_0007 to 0x1000 → FAIL; `fail_code`=3; `pass`=0. A later store of 32'h1 leaves the state FAIL.
- Store 32'h1 with strobe 4'h3, then store 0 with strobe F → state stays RUN; a load of 0x1000 returns 0 one cycle later with `rd_resp_valid` high for one cycle.
- With `TIMEOUT`=50 and no stores → TIMEOUT at `cycles`=50; `fail_code`=31'h7FFF_FFFF; `done`=1. With the macro undefined → still RUN at cycle 200.
- Store 32'h1 in the same cycle the watchdog limit is reached → PASS, not TIMEOUT.
- After PASS, drop reset mid-run → all outputs 0 and state RUN; `cycles` restarts from 0 after release.
